// File: rtl/spi_poll_sequencer_pkg.sv
// Shared definitions for the SPI poll sequencer.
// Contents: FSM state encoding, sensor data register addresses, recovery
// length, and the configuration table written after every (re)initialisation.
package spi_poll_sequencer_pkg;

   typedef enum logic [2:0] {
      INIT_WR,
      WAIT_INT,
      RD_LO,
      RD_HI,
      PUBLISH,
      RECOVER
   } state_e;

   localparam logic [5:0]  ADDR_DATA_LO   = 6'h32;
   localparam logic [5:0]  ADDR_DATA_HI   = 6'h33;
   localparam int unsigned RECOVER_CYCLES = 16;

   typedef struct packed {
      logic [5:0] addr;
      logic [7:0] data;
   } init_entry_t;

   // Sensor configuration, written in index order.
   function automatic init_entry_t init_entry(input logic [2:0] idx);
      init_entry_t e;
      case (idx)
         3'd0:    e = '{addr: 6'h31, data: 8'h40};
         3'd1:    e = '{addr: 6'h2C, data: 8'h09};
         3'd2:    e = '{addr: 6'h2F, data: 8'h00};
         3'd3:    e = '{addr: 6'h2E, data: 8'h80};
         3'd4:    e = '{addr: 6'h2D, data: 8'h08};
         default: e = '{addr: 6'h00, data: 8'h00};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/spi_poll_sequencer_int_sync.sv
// int_edge_sync: brings an asynchronous level into the iCLK domain through a
// two-flop synchronizer and emits a one-cycle pulse on its rising edge.
// Ports:
//   iCLK    in  clock
//   iRSTN   in  asynchronous active-low reset (clears the synchronizer)
//   iASYNC  in  asynchronous level input
//   oPULSE  out one-cycle pulse on a synchronized 0->1 transition
module int_edge_sync
   import spi_poll_sequencer_pkg::*;
(
   input  logic iCLK,
   input  logic iRSTN,
   input  logic iASYNC,
   output logic oPULSE
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = iASYNC;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign oPULSE = sync_q & ~prev_q;

endmodule

// File: rtl/spi_poll_sequencer.sv
// spi_poll_sequencer: configures an SPI sensor after reset, then on every
// data-ready interrupt reads the X sample (low byte, then high byte) through a
// request/ack SPI byte engine and publishes the 10-bit result.
// Ports:
//   iCLK, iRSTN          clock, asynchronous active-low reset
//   iG_INT1              asynchronous data-ready interrupt
//   iSPI_ACK/iSPI_RDATA  byte engine done pulse and read byte
//   oSPI_REQ/RW/ADDR/WDATA  transfer request (level) and its attributes
//   oDIG/oDIG_VLD        latest sample and its one-cycle update strobe
//   oINIT_DONE           configuration table fully written
//   oERR/oOVR            sticky ack-timeout and interrupt-overrun flags
module spi_poll_sequencer
   import spi_poll_sequencer_pkg::*;
#(
   parameter logic [15:0] ACK_TIMEOUT = 16'd2000,
   parameter int          INIT_LEN    = 5
)(
   input  logic       iCLK,
   input  logic       iRSTN,
   input  logic       iG_INT1,
   input  logic       iSPI_ACK,
   input  logic [7:0] iSPI_RDATA,
   output logic       oSPI_REQ,
   output logic       oSPI_RW,
   output logic [5:0] oSPI_ADDR,
   output logic [7:0] oSPI_WDATA,
   output logic [9:0] oDIG,
   output logic       oDIG_VLD,
   output logic       oINIT_DONE,
   output logic       oERR,
   output logic       oOVR
);

   localparam logic [2:0] LAST_IDX  = 3'(INIT_LEN - 1);
   localparam logic [3:0] LAST_RCNT = 4'(RECOVER_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        req_q, req_d;
   logic        rw_q, rw_d;
   logic [5:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  lo_q, lo_d;
   logic [9:0]  dig_q, dig_d;
   logic        dig_vld_q, dig_vld_d;
   logic        init_done_q, init_done_d;
   logic        err_q, err_d;
   logic        ovr_q, ovr_d;
   logic        pend_q, pend_d;
   logic        arm_q, arm_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [3:0]  rcnt_q, rcnt_d;

   logic        int_evt;
   logic        ack_seen;
   logic        timeout;
   init_entry_t entry;

   int_edge_sync u_int_sync (
      .iCLK   (iCLK),
      .iRSTN  (iRSTN),
      .iASYNC (iG_INT1),
      .oPULSE (int_evt)
   );

   // An ack only counts while a request is outstanding.
   assign ack_seen = iSPI_ACK & req_q;
   assign timeout  = req_q & ~iSPI_ACK & (tcnt_q == ACK_TIMEOUT - 16'd1);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      req_d       = req_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lo_d        = lo_q;
      dig_d       = dig_q;
      dig_vld_d   = 1'b0;
      init_done_d = init_done_q;
      err_d       = err_q;
      ovr_d       = ovr_q;
      pend_d      = pend_q;
      rcnt_d      = rcnt_q;
      arm_d       = 1'b1;
      entry       = init_entry(idx_q);

      // Interrupts arriving while busy are remembered one deep.
      if (int_evt && (state_q != WAIT_INT)) begin
         if (pend_q) ovr_d = 1'b1;
         pend_d = 1'b1;
      end

      case (state_q)
         INIT_WR: begin
            if (ack_seen) begin
               req_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d     = WAIT_INT;
                  idx_d       = '0;
                  init_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else if (!req_q && arm_q) begin
               // arm_q holds off the very first request by one edge after reset.
               req_d   = 1'b1;
               rw_d    = 1'b0;
               addr_d  = entry.addr;
               wdata_d = entry.data;
            end
         end
         WAIT_INT: begin
            if (int_evt || pend_q) begin
               state_d = RD_LO;
               // Event and stored flag together: one is served, one stays queued.
               pend_d  = int_evt && pend_q;
            end
         end
         RD_LO: begin
            if (ack_seen) begin
               req_d   = 1'b0;
               lo_d    = iSPI_RDATA;
               state_d = RD_HI;
            end else if (!req_q) begin
               req_d   = 1'b1;
               rw_d    = 1'b1;
               addr_d  = ADDR_DATA_LO;
               wdata_d = 8'h00;
            end
         end
         RD_HI: begin
            if (ack_seen) begin
               req_d     = 1'b0;
               dig_d     = {iSPI_RDATA[1:0], lo_q};
               dig_vld_d = 1'b1;
               state_d   = PUBLISH;
            end else if (!req_q) begin
               req_d   = 1'b1;
               rw_d    = 1'b1;
               addr_d  = ADDR_DATA_HI;
               wdata_d = 8'h00;
            end
         end
         PUBLISH: begin
            state_d = WAIT_INT;
         end
         RECOVER: begin
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == LAST_RCNT) begin
               // Restart init and issue entry 0 on the same edge.
               state_d     = INIT_WR;
               idx_d       = '0;
               init_done_d = 1'b0;
               pend_d      = 1'b0;
               rcnt_d      = '0;
               req_d       = 1'b1;
               rw_d        = 1'b0;
               addr_d      = entry.addr;
               wdata_d     = entry.data;
            end
         end
         default: state_d = INIT_WR;
      endcase

      if (timeout) begin
         req_d   = 1'b0;
         err_d   = 1'b1;
         idx_d   = '0;
         rcnt_d  = '0;
         state_d = RECOVER;
      end

      // Counts cycles of the current request; zero during its first cycle.
      tcnt_d = (req_q && req_d) ? tcnt_q + 16'd1 : 16'd0;
   end

   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         state_q     <= INIT_WR;
         idx_q       <= '0;
         req_q       <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lo_q        <= '0;
         dig_q       <= '0;
         dig_vld_q   <= 1'b0;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
         ovr_q       <= 1'b0;
         pend_q      <= 1'b0;
         arm_q       <= 1'b0;
         tcnt_q      <= '0;
         rcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         req_q       <= req_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lo_q        <= lo_d;
         dig_q       <= dig_d;
         dig_vld_q   <= dig_vld_d;
         init_done_q <= init_done_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
         pend_q      <= pend_d;
         arm_q       <= arm_d;
         tcnt_q      <= tcnt_d;
         rcnt_q      <= rcnt_d;
      end
   end

   assign oSPI_REQ   = req_q;
   assign oSPI_RW    = rw_q;
   assign oSPI_ADDR  = addr_q;
   assign oSPI_WDATA = wdata_q;
   assign oDIG       = dig_q;
   assign oDIG_VLD   = dig_vld_q;
   assign oINIT_DONE = init_done_q;
   assign oERR       = err_q;
   assign oOVR       = ovr_q;

endmodule

// File: tb/tb_spi_poll_sequencer.sv
// Bench for spi_poll_sequencer: an SPI byte-engine model that acks a
// configurable number of cycles after each request, a transaction log, and a
// sample-level reference model of the published X value.
module tb_spi_poll_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, g_int, ack;
   logic [7:0] rdata;
   logic       req, rw;
   logic [5:0] addr;
   logic [7:0] wdata;
   logic [9:0] dig;
   logic       dig_vld, init_done, err, ovr;

   spi_poll_sequencer #(.ACK_TIMEOUT(16'd100), .INIT_LEN(5)) dut (
      .iCLK       (clk),
      .iRSTN      (rst_n),
      .iG_INT1    (g_int),
      .iSPI_ACK   (ack),
      .iSPI_RDATA (rdata),
      .oSPI_REQ   (req),
      .oSPI_RW    (rw),
      .oSPI_ADDR  (addr),
      .oSPI_WDATA (wdata),
      .oDIG       (dig),
      .oDIG_VLD   (dig_vld),
      .oINIT_DONE (init_done),
      .oERR       (err),
      .oOVR       (ovr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] lo;
      logic [7:0] hi;
      logic [9:0] exp_dig;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   vec_t        vecs [6];
   logic [13:0] init_tab [5];
   logic [14:0] log_q [$];   // {rw, addr, wdata} of every acked transfer
   logic [7:0]  rd_q  [$];   // bytes the engine model returns for reads
   logic [9:0]  vld_q [$];   // oDIG seen at each oDIG_VLD
   logic [9:0]  exp_q [$];   // samples the reference model predicts
   bit          ack_en  = 1'b1;
   bit          spur_en = 1'b0;
   int unsigned ack_dly = 3;
   int unsigned ncyc = 0, age = 0, low_len = 0, last_gap = 0, last_hi = 0;
   int unsigned rise_cnt = 0, hi_ack_ncyc = 0, vld_ncyc = 0, vld_gap = 0;
   logic [14:0] rise_attr = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Sample value from the two bytes: 2 low bits of hi above all 8 bits of lo.
   function automatic logic [9:0] model_dig(input logic [7:0] lo, input logic [7:0] hi);
      int v;
      v = (int'(hi) % 4) * 256 + int'(lo);
      return v[9:0];
   endfunction

   // SPI byte-engine model and output monitor, evaluated on every falling edge.
   initial begin
      ack   = 1'b0;
      rdata = 8'h00;
      forever begin
         @(negedge clk);
         ack   = 1'b0;
         rdata = 8'h00;
         ncyc++;
         if (dig_vld) begin
            vld_q.push_back(dig);
            vld_gap  = ncyc - vld_ncyc;
            vld_ncyc = ncyc;
         end
         if (!rst_n) begin
            age     = 0;
            low_len = 0;
         end else if (req) begin
            if (age == 0) begin
               last_gap  = low_len;
               rise_attr = {rw, addr, wdata};
               rise_cnt++;
            end
            age++;
            low_len = 0;
            if (ack_en && age == ack_dly) begin
               chk("hs_stable", 32'({rw, addr, wdata}), 32'(rise_attr));
               ack = 1'b1;
               log_q.push_back({rw, addr, wdata});
               if (rw) rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
               if (rw && addr == 6'h33) hi_ack_ncyc = ncyc;
            end
         end else begin
            if (age != 0) last_hi = age;
            age = 0;
            low_len++;
            if (spur_en && $urandom_range(0, 3) == 0) begin
               ack   = 1'b1;
               rdata = 8'($urandom);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic int_pulse();
      @(negedge clk);
      g_int = 1'b1;
      repeat (3) @(negedge clk);
      g_int = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk(nm, 32'({req, rw, addr, wdata, dig, dig_vld, init_done, err, ovr}), 32'd0);
   endtask

   task automatic wait_init(input string nm);
      int base;
      int k;
      base = log_q.size();
      k = 0;
      while (!init_done && k < 300) begin
         tick();
         k++;
      end
      chk({nm, "_done"}, 32'(init_done), 32'd1);
      chk({nm, "_writes"}, 32'(log_q.size() - base), 32'd5);
      for (int i = 0; i < 5; i++)
         if (base + i < log_q.size())
            chk({nm, "_entry"}, 32'(log_q[base + i]), 32'({1'b0, init_tab[i]}));
   endtask

   task automatic wait_req_addr(input logic [5:0] a, input string nm);
      int k;
      k = 0;
      while (!(req && addr == a) && k < 100) begin
         tick();
         k++;
      end
      chk(nm, 32'(req && addr == a), 32'd1);
   endtask

   task automatic wait_vlds(input int n, input string nm);
      int k;
      k = 0;
      while (vld_q.size() < n && k < 400) begin
         tick();
         k++;
      end
      chk(nm, 32'(vld_q.size() >= n), 32'd1);
   endtask

   task automatic drain(input string nm);
      while (exp_q.size() > 0) begin
         if (vld_q.size() > 0) begin
            chk(nm, 32'(vld_q.pop_front()), 32'(exp_q.pop_front()));
         end else begin
            chk({nm, "_missing"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
         end
      end
      chk({nm, "_extra"}, 32'(vld_q.size()), 32'd0);
      vld_q.delete();
   endtask

   initial begin
      logic [7:0] lo, hi;
      logic [9:0] dig_before;
      int         k;
      int unsigned r0;

      vecs[0] = '{8'hF0, 8'h03, 10'h3F0};
      vecs[1] = '{8'h00, 8'h00, 10'h000};
      vecs[2] = '{8'hFF, 8'hFF, 10'h3FF};
      vecs[3] = '{8'h01, 8'h02, 10'h201};
      vecs[4] = '{8'h80, 8'hFC, 10'h080};
      vecs[5] = '{8'h7F, 8'h01, 10'h17F};
      init_tab[0] = {6'h31, 8'h40};
      init_tab[1] = {6'h2C, 8'h09};
      init_tab[2] = {6'h2F, 8'h00};
      init_tab[3] = {6'h2E, 8'h80};
      init_tab[4] = {6'h2D, 8'h08};

      rst_n = 1'b0;
      g_int = 1'b0;

      // Reset and configuration
      repeat (3) @(negedge clk);
      chk_reset_outs("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("req_first_edge", 32'(req), 32'd0);
      wait_init("init");

      // Table of single reads
      for (int i = 0; i < 6; i++) begin
         rd_q.push_back(vecs[i].lo);
         rd_q.push_back(vecs[i].hi);
         exp_q.push_back(vecs[i].exp_dig);
         int_pulse();
         wait_vlds(1, "tbl_vld");
         chk("tbl_vld_latency", 32'(vld_ncyc - hi_ack_ncyc), 32'd1);
         repeat (4) tick();
         chk("tbl_rd_addrs",
             32'({log_q[log_q.size() - 2][13:8], log_q[log_q.size() - 1][13:8]}),
             32'({6'h32, 6'h33}));
         drain("tbl_dig");
      end

      // Second interrupt swept across RD_HI / PUBLISH / WAIT_INT
      ack_dly = 3;
      for (int off = 0; off < 5; off++) begin
         lo = 8'h10 + 8'(off);
         rd_q.push_back(lo);
         rd_q.push_back(8'h01);
         rd_q.push_back(lo + 8'h20);
         rd_q.push_back(8'h02);
         exp_q.push_back(model_dig(lo, 8'h01));
         exp_q.push_back(model_dig(lo + 8'h20, 8'h02));
         int_pulse();
         wait_req_addr(6'h33, "pub_hi_req");
         repeat (off) @(negedge clk);
         @(negedge clk);
         g_int = 1'b1;
         repeat (3) @(negedge clk);
         g_int = 1'b0;
         wait_vlds(2, "pub_vld");
         repeat (4) tick();
         drain("pub_dig");
      end
      chk("pub_ovr", 32'(ovr), 32'd0);

      // One extra interrupt during the read: queued, no overrun
      ack_dly = 10;
      rd_q.push_back(8'hA5); rd_q.push_back(8'h01);
      rd_q.push_back(8'h5A); rd_q.push_back(8'h02);
      exp_q.push_back(model_dig(8'hA5, 8'h01));
      exp_q.push_back(model_dig(8'h5A, 8'h02));
      int_pulse();
      wait_req_addr(6'h32, "pend_lo_req");
      int_pulse();
      wait_vlds(2, "pend_vld");
      // Queued read follows PUBLISH directly: idle cycle, issue cycle,
      // two transfers of ack_dly plus one turnaround each.
      chk("pend_prompt", 32'(vld_gap <= 2 * ack_dly + 6), 32'd1);
      repeat (4) tick();
      drain("pend_dig");
      chk("pend_ovr", 32'(ovr), 32'd0);

      // Randomised reads with spurious acks while no request is pending
      spur_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ack_dly = $urandom_range(1, 6);
         lo = 8'($urandom);
         hi = 8'($urandom);
         rd_q.push_back(lo);
         rd_q.push_back(hi);
         exp_q.push_back(model_dig(lo, hi));
         int_pulse();
         wait_vlds(1, "rnd_vld");
         repeat (3) tick();
         drain("rnd_dig");
      end
      spur_en = 1'b0;
      chk("rnd_err", 32'(err), 32'd0);
      chk("rnd_ovr", 32'(ovr), 32'd0);

      // Third interrupt in the same window: overrun
      ack_dly = 10;
      rd_q.push_back(8'h11); rd_q.push_back(8'h03);
      rd_q.push_back(8'h22); rd_q.push_back(8'h00);
      exp_q.push_back(model_dig(8'h11, 8'h03));
      exp_q.push_back(model_dig(8'h22, 8'h00));
      int_pulse();
      wait_req_addr(6'h32, "ovr_lo_req");
      int_pulse();
      int_pulse();
      wait_vlds(2, "ovr_vld");
      repeat (30) tick();
      drain("ovr_dig");
      chk("ovr_set", 32'(ovr), 32'd1);

      // Silent engine: timeout, recovery and re-init
      dig_before = dig;
      ack_en = 1'b0;
      int_pulse();
      k = 0;
      while (!err && k < 300) begin
         tick();
         k++;
      end
      chk("to_err", 32'(err), 32'd1);
      tick();
      tick();
      chk("to_req_high_cycles", 32'(last_hi), 32'd100);
      chk("to_req_low", 32'(req), 32'd0);
      r0 = rise_cnt;
      ack_dly = 3;
      ack_en = 1'b1;
      k = 0;
      while (rise_cnt == r0 && k < 40) begin
         tick();
         k++;
      end
      chk("to_reinit_rise", 32'(rise_cnt != r0), 32'd1);
      chk("to_reinit_gap", 32'(last_gap), 32'd16);
      chk("to_init_done_clr", 32'(init_done), 32'd0);
      wait_init("reinit");
      chk("to_dig_hold", 32'(dig), 32'(dig_before));
      chk("to_err_sticky", 32'(err), 32'd1);
      chk("to_ovr_sticky", 32'(ovr), 32'd1);

      // Reset while the high-byte read is outstanding
      ack_dly = 8;
      rd_q.push_back(8'h33);
      rd_q.push_back(8'h01);
      int_pulse();
      wait_req_addr(6'h33, "rst_hi_req");
      rst_n = 1'b0;
      #1;
      chk_reset_outs("rst_mid");
      rd_q.delete();
      repeat (2) @(negedge clk);
      chk_reset_outs("rst_hold");
      ack_dly = 3;
      rst_n = 1'b1;
      wait_init("rst_reinit");
      repeat (4) tick();
      drain("rst_dig");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
